// File: rtl/opb_stage.sv
// Operand-B stage: resolves rs2 through the forwarding network, selects operand B,
// stalls on load-use hazards and registers the result behind a 2-entry skid buffer.
`timescale 1ns/1ps
module opb_stage #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_flush,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [1:0]              i_opb_sel,
  input  logic                    i_need_rs2,
  input  logic [4:0]              i_rs2_addr,
  input  logic [XLEN-1:0]         i_rs2_data,
  input  logic [XLEN-1:0]         i_imm,
  input  logic [NUM_FWD-1:0]      i_fwd_valid,
  input  logic [NUM_FWD-1:0]      i_fwd_pending,
  input  logic [5*NUM_FWD-1:0]    i_fwd_rd,
  input  logic [XLEN*NUM_FWD-1:0] i_fwd_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [XLEN-1:0]         o_operand_b,
  output logic [XLEN-1:0]         o_store_data,
  output logic                    o_hazard
);

  function automatic logic [XLEN-1:0] sel_opb(input logic [1:0] sel,
                                              input logic [XLEN-1:0] rs2,
                                              input logic [XLEN-1:0] imm);
    sel_opb = '0;
    case (sel)
      2'd0:    sel_opb = rs2;
      2'd1:    sel_opb = imm;
      2'd2:    sel_opb[2] = 1'b1;
      default: sel_opb = '0;
    endcase
  endfunction

  logic [XLEN-1:0] rs2_p0;
  logic [XLEN-1:0] opb_p0;
  logic            win_pend_p0;
  logic            accept_p0;
  logic            load_out;

  logic            vld_p1;
  logic [XLEN-1:0] opb_p1;
  logic [XLEN-1:0] store_p1;
  logic            skid_vld_p1;
  logic [XLEN-1:0] skid_opb_p1;
  logic [XLEN-1:0] skid_store_p1;

  // Stage p0: forwarding resolution, hazard detection and operand selection.
  always_comb begin
    rs2_p0      = i_rs2_data;
    win_pend_p0 = 1'b0;
    // Walk from lowest priority up so the youngest matching source overrides.
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (i_fwd_valid[k] && (i_fwd_rd[5*k +: 5] == i_rs2_addr)) begin
        rs2_p0      = i_fwd_data[XLEN*k +: XLEN];
        win_pend_p0 = i_fwd_pending[k];
      end
    end
    if (i_rs2_addr == 5'd0) begin
      rs2_p0      = '0;
      win_pend_p0 = 1'b0;
    end
  end

  assign opb_p0    = sel_opb(i_opb_sel, rs2_p0, i_imm);
  assign o_hazard  = i_valid & i_need_rs2 & win_pend_p0;
  assign o_ready   = ~skid_vld_p1;
  assign accept_p0 = i_valid & o_ready & ~o_hazard & ~i_flush;
  assign load_out  = ~vld_p1 | i_ready;

  // Stage p1: output register with skid entry behind it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p1        <= 1'b0;
      skid_vld_p1   <= 1'b0;
      opb_p1        <= '0;
      store_p1      <= '0;
      skid_opb_p1   <= '0;
      skid_store_p1 <= '0;
    end else if (i_flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (load_out) begin
      if (skid_vld_p1) begin
        // o_ready is low here, so no new request competes with the drain.
        opb_p1      <= skid_opb_p1;
        store_p1    <= skid_store_p1;
        vld_p1      <= 1'b1;
        skid_vld_p1 <= 1'b0;
      end else begin
        vld_p1 <= accept_p0;
        if (accept_p0) begin
          opb_p1   <= opb_p0;
          store_p1 <= rs2_p0;
        end
      end
    end else if (accept_p0) begin
      skid_opb_p1   <= opb_p0;
      skid_store_p1 <= rs2_p0;
      skid_vld_p1   <= 1'b1;
    end
  end

  assign o_valid      = vld_p1;
  assign o_operand_b  = opb_p1;
  assign o_store_data = store_p1;

endmodule

// File: tb/tb_opb_stage.sv
// Bench for opb_stage: directed vector table, hand-written multi-cycle sequences
// and randomized traffic against a depth-2 FIFO reference model.
`timescale 1ns/1ps
module tb_opb_stage;
  localparam int XLEN = 32;
  localparam int NF   = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            valid = 1'b0;
  logic            rdy_out;
  logic [1:0]      sel = '0;
  logic            need = 1'b0;
  logic [4:0]      addr = '0;
  logic [XLEN-1:0] rs2d = '0;
  logic [XLEN-1:0] imm = '0;
  logic [NF-1:0]   fv = '0;
  logic [NF-1:0]   fp = '0;
  logic [5*NF-1:0] frd = '0;
  logic [XLEN*NF-1:0] fdata = '0;
  logic            vld_out;
  logic            rdy_in = 1'b1;
  logic [XLEN-1:0] opb;
  logic [XLEN-1:0] store;
  logic            hz;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  opb_stage #(.XLEN(XLEN), .NUM_FWD(NF)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(rdy_out),
    .i_opb_sel(sel), .i_need_rs2(need), .i_rs2_addr(addr), .i_rs2_data(rs2d), .i_imm(imm),
    .i_fwd_valid(fv), .i_fwd_pending(fp), .i_fwd_rd(frd), .i_fwd_data(fdata),
    .o_valid(vld_out), .i_ready(rdy_in), .o_operand_b(opb), .o_store_data(store),
    .o_hazard(hz)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic        need;
    logic [4:0]  addr;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [1:0]  fv;
    logic [1:0]  fp;
    logic [9:0]  frd;
    logic [63:0] fdata;
    logic [31:0] eb;
    logic [31:0] es;
    logic        ehz;
  } vec_t;

  vec_t vecs[11];

  task automatic drive(input vec_t v);
    sel = v.sel; need = v.need; addr = v.addr; rs2d = v.rs2; imm = v.imm;
    fv = v.fv; fp = v.fp; frd = v.frd; fdata = v.fdata;
  endtask

  task automatic req(input logic [31:0] value);
    sel = 2'd1; need = 1'b0; addr = 5'd0; rs2d = 32'h0; imm = value;
    fv = '0; fp = '0; frd = '0; fdata = '0;
  endtask

  // Reference: x0 reads as zero; otherwise the first valid source whose rd matches
  // (in priority order) supplies the value, else the register file does.
  task automatic ref_resolve(output logic [31:0] val, output logic pend);
    val  = rs2d;
    pend = 1'b0;
    if (addr == 5'd0) begin
      val = 32'h0;
    end else begin
      for (int k = 0; k < NF; k++) begin
        if (fv[k] && frd[5*k +: 5] == addr) begin
          val  = fdata[32*k +: 32];
          pend = fp[k];
          break;
        end
      end
    end
  endtask

  function automatic logic [31:0] ref_opb(input logic [1:0] s, input logic [31:0] r,
                                          input logic [31:0] i);
    case (s)
      2'd0:    return r;
      2'd1:    return i;
      2'd2:    return 32'd4;
      default: return 32'd0;
    endcase
  endfunction

  logic [31:0] q_b[$];
  logic [31:0] q_s[$];

  initial begin
    logic [31:0] res;
    logic        pend;
    logic        exp_hz;
    logic        acc;
    logic        cons;

    //             sel  need addr rs2          imm          fv     fp     frd            fdata                      eb           es           hz
    vecs[0]  = '{2'd0, 1'b1, 5'd5, 32'h1111, 32'h0, 2'b11, 2'b00, {5'd5, 5'd5}, {32'hBBBB, 32'hAAAA}, 32'hAAAA, 32'hAAAA, 1'b0};
    vecs[1]  = '{2'd0, 1'b1, 5'd5, 32'h1111, 32'h0, 2'b11, 2'b00, {5'd5, 5'd6}, {32'hBBBB, 32'hAAAA}, 32'hBBBB, 32'hBBBB, 1'b0};
    vecs[2]  = '{2'd0, 1'b1, 5'd9, 32'h11112222, 32'h0, 2'b11, 2'b00, {5'd5, 5'd6}, {32'hBBBB, 32'hAAAA}, 32'h11112222, 32'h11112222, 1'b0};
    vecs[3]  = '{2'd0, 1'b1, 5'd0, 32'h5555, 32'h0, 2'b01, 2'b00, {5'd0, 5'd0}, {32'h0, 32'hDEAD}, 32'h0, 32'h0, 1'b0};
    vecs[4]  = '{2'd1, 1'b1, 5'd3, 32'h5555, 32'hFFFFF800, 2'b01, 2'b00, {5'd0, 5'd3}, {32'h0, 32'h33}, 32'hFFFFF800, 32'h33, 1'b0};
    vecs[5]  = '{2'd2, 1'b0, 5'd4, 32'hCAFE0000, 32'h77, 2'b00, 2'b00, {5'd0, 5'd0}, 64'h0, 32'd4, 32'hCAFE0000, 1'b0};
    vecs[6]  = '{2'd3, 1'b0, 5'd4, 32'hCAFE0000, 32'h77, 2'b00, 2'b00, {5'd0, 5'd0}, 64'h0, 32'd0, 32'hCAFE0000, 1'b0};
    vecs[7]  = '{2'd0, 1'b1, 5'd7, 32'h1, 32'h0, 2'b01, 2'b01, {5'd0, 5'd7}, {32'h0, 32'h9999}, 32'h0, 32'h0, 1'b1};
    vecs[8]  = '{2'd0, 1'b1, 5'd7, 32'h1, 32'h0, 2'b11, 2'b10, {5'd7, 5'd7}, {32'h88, 32'h77}, 32'h77, 32'h77, 1'b0};
    vecs[9]  = '{2'd1, 1'b0, 5'd7, 32'h1, 32'h1234ABCD, 2'b01, 2'b01, {5'd0, 5'd7}, {32'h0, 32'h42}, 32'h1234ABCD, 32'h42, 1'b0};
    vecs[10] = '{2'd0, 1'b1, 5'd8, 32'hF00D, 32'h0, 2'b00, 2'b00, {5'd8, 5'd8}, {32'h1, 32'h2}, 32'hF00D, 32'hF00D, 1'b0};

    // Reset state
    #12;
    chk("reset_valid", 32'(vld_out), 32'd0);
    chk("reset_ready", 32'(rdy_out), 32'd1);
    chk("reset_opb", opb, 32'd0);
    chk("reset_store", store, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Vector table, downstream always ready
    rdy_in = 1'b1;
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i]);
      valid = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d_hazard", i), 32'(hz), 32'(vecs[i].ehz));
      @(posedge clk); #1;
      valid = 1'b0;
      if (!vecs[i].ehz) begin
        chk($sformatf("vec%0d_valid", i), 32'(vld_out), 32'd1);
        chk($sformatf("vec%0d_opb", i), opb, vecs[i].eb);
        chk($sformatf("vec%0d_store", i), store, vecs[i].es);
      end else begin
        chk($sformatf("vec%0d_stall_valid", i), 32'(vld_out), 32'd0);
      end
    end
    @(posedge clk); #1;
    chk("table_drain", 32'(vld_out), 32'd0);

    // Load-use stall, then release with the load result
    req(32'h0);
    sel = 2'd0; need = 1'b1; addr = 5'd7; fv = 2'b01; fp = 2'b01;
    frd = {5'd0, 5'd7}; fdata = 64'h0;
    valid = 1'b1;
    @(negedge clk);
    chk("lu_hazard", 32'(hz), 32'd1);
    @(posedge clk); #1;
    chk("lu_no_accept", 32'(vld_out), 32'd0);
    fp = 2'b00; fdata = {32'h0, 32'h1234};
    @(negedge clk);
    chk("lu_hazard_clear", 32'(hz), 32'd0);
    @(posedge clk); #1;
    valid = 1'b0;
    chk("lu_valid", 32'(vld_out), 32'd1);
    chk("lu_opb", opb, 32'h1234);
    @(posedge clk); #1;

    // Backpressure: three back-to-back requests with the sink stalled
    rdy_in = 1'b0;
    req(32'hA1); valid = 1'b1;
    @(negedge clk); chk("bp_ready_1", 32'(rdy_out), 32'd1);
    @(posedge clk); #1; req(32'hB2);
    @(negedge clk); chk("bp_ready_2", 32'(rdy_out), 32'd1);
    @(posedge clk); #1; req(32'hC3);
    @(negedge clk);
    chk("bp_ready_full", 32'(rdy_out), 32'd0);
    chk("bp_valid", 32'(vld_out), 32'd1);
    chk("bp_head", opb, 32'hA1);
    @(posedge clk); #1;
    chk("bp_stable", opb, 32'hA1);
    rdy_in = 1'b1;
    @(negedge clk); chk("bp_ready_still_full", 32'(rdy_out), 32'd0);
    @(posedge clk); #1;
    chk("bp_second", opb, 32'hB2);
    chk("bp_ready_after_drain", 32'(rdy_out), 32'd1);
    @(posedge clk); #1;
    valid = 1'b0;
    chk("bp_third", opb, 32'hC3);
    chk("bp_third_valid", 32'(vld_out), 32'd1);
    @(posedge clk); #1;
    chk("bp_empty", 32'(vld_out), 32'd0);

    // Flush with a full skid buffer and a same-cycle request
    rdy_in = 1'b0;
    req(32'hD4); valid = 1'b1;
    @(posedge clk); #1; req(32'hE5);
    @(posedge clk); #1;
    chk("fl_full", 32'(rdy_out), 32'd0);
    req(32'hF6); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; valid = 1'b0;
    chk("fl_valid", 32'(vld_out), 32'd0);
    chk("fl_ready", 32'(rdy_out), 32'd1);
    rdy_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("fl_quiet%0d", i), 32'(vld_out), 32'd0);
    end

    // Reset mid-stream with two entries held
    rdy_in = 1'b0;
    req(32'h1357); valid = 1'b1;
    @(posedge clk); #1; req(32'h2468);
    @(posedge clk); #1; valid = 1'b0;
    chk("rst_full", 32'(rdy_out), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(vld_out), 32'd0);
    chk("rst_mid_ready", 32'(rdy_out), 32'd1);
    chk("rst_mid_opb", opb, 32'd0);
    chk("rst_mid_store", store, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_after_valid", 32'(vld_out), 32'd0);
    chk("rst_after_ready", 32'(rdy_out), 32'd1);

    // Randomized traffic against a depth-2 FIFO model
    for (int i = 0; i < 600; i++) begin
      valid  = ($urandom_range(0, 3) != 0);
      flush  = ($urandom_range(0, 15) == 0);
      rdy_in = ($urandom_range(0, 2) != 0);
      sel    = 2'($urandom);
      need   = 1'($urandom);
      addr   = 5'($urandom_range(0, 3));
      rs2d   = $urandom;
      imm    = $urandom;
      fv     = 2'($urandom);
      fp     = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      frd    = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      fdata  = {$urandom, $urandom};
      ref_resolve(res, pend);
      exp_hz = valid & need & pend;
      @(negedge clk);
      chk("rnd_hazard", 32'(hz), 32'(exp_hz));
      chk("rnd_valid", 32'(vld_out), 32'(q_b.size() > 0));
      chk("rnd_ready", 32'(rdy_out), 32'(q_b.size() < 2));
      if (q_b.size() > 0) begin
        chk("rnd_opb", opb, q_b[0]);
        chk("rnd_store", store, q_s[0]);
      end
      acc  = valid && (q_b.size() < 2) && !exp_hz && !flush;
      cons = (q_b.size() > 0) && rdy_in;
      @(posedge clk); #1;
      if (flush) begin
        q_b.delete();
        q_s.delete();
      end else begin
        if (cons) begin
          void'(q_b.pop_front());
          void'(q_s.pop_front());
        end
        if (acc) begin
          q_b.push_back(ref_opb(sel, res, imm));
          q_s.push_back(res);
        end
      end
    end
    valid = 1'b0;
    flush = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
